// File: rtl/m6809_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m6809_reset_pkg
// Description : Shared types and constants for the 6809 SOC reset sequencer:
//               sequencer state encoding, reset-cause bit positions and a
//               one-hot helper for building cause masks.
// Revision    : 1.0 - initial release
// ============================================================================
package m6809_reset_pkg;

    // Sequencer states: hold everything, staggered release, normal operation
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int CAUSE_W   = 4;
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_EXT = 1;
    localparam int CAUSE_SW  = 2;
    localparam int CAUSE_WDT = 3;

    // One-hot mask for a cause bit position
    function automatic logic [CAUSE_W-1:0] cause_bit(input int idx);
        logic [CAUSE_W-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage : m6809_reset_pkg
`default_nettype wire

// File: rtl/m6809_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : m6809_sync_debounce
// Description : Two-flop synchroniser followed by a debouncer for the
//               active-low external reset button. The debounced level only
//               changes after DEBOUNCE_CYCLES consecutive identical
//               synchronised samples that differ from the current level.
// Revision    : 1.0 - initial release
// ============================================================================
module m6809_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ext_b,
    output logic o_level_b
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shift the raw input through the synchroniser; count consecutive
    // synchronised samples that disagree with the accepted level
    always_comb begin
        sync_d  = {sync_q[0], i_ext_b};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Idle state is "button released" so reset does not look like a press
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level_b = level_q;

endmodule : m6809_sync_debounce
`default_nettype wire

// File: rtl/m6809_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : m6809_reset_seq
// Description : Reset sequencer for the 6809 SOC. Merges power-on, external
//               button, software and (optional) watchdog reset sources,
//               stretches the reset, releases NUM_DOMAINS active-low resets
//               in staggered order and keeps a sticky reset-cause register.
//               Build option: define M6809_WDT_EN to include the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module m6809_reset_seq
    import m6809_reset_pkg::*;
#(
    parameter int NUM_DOMAINS     = 3,
    parameter int STRETCH_CYCLES  = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int WDT_CYCLES      = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_reset_b,
    input  logic                   sw_reset_req,
    input  logic                   wdt_enable,
    input  logic                   wdt_kick,
    input  logic                   cause_clr,
    output logic [NUM_DOMAINS-1:0] reset_b_out,
    output logic                   seq_busy,
    output logic [CAUSE_W-1:0]     reset_cause
);
    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NUM_DOMAINS) + 1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] reset_b_q, reset_b_d;
    logic                   busy_q, busy_d;
    logic [CAUSE_W-1:0]     cause_q, cause_d;

    logic w_ext_level_b;
    logic w_ext_low;
    logic w_wdt_fire;
    logic w_req;

    m6809_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk       (clk),
        .rst       (reset),
        .i_ext_b   (ext_reset_b),
        .o_level_b (w_ext_level_b)
    );

    assign w_ext_low = ~w_ext_level_b;

`ifdef M6809_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES) + 1;

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

    // Watchdog counts enabled RUN cycles; a kick or leaving RUN restarts it
    always_comb begin
        wdt_cnt_d  = '0;
        w_wdt_fire = 1'b0;
        if (state_q == RUN && !wdt_kick) begin
            if (wdt_enable) begin
                if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
                    w_wdt_fire = 1'b1;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + 1'b1;
                end
            end else begin
                wdt_cnt_d = wdt_cnt_q;
            end
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
        end
    end
`else
    logic w_unused_wdt;

    assign w_wdt_fire   = 1'b0;
    assign w_unused_wdt = ^{wdt_enable, wdt_kick, WDT_CYCLES};
`endif

    assign w_req = w_ext_low | sw_reset_req | w_wdt_fire;

    // Sequencer next state: any request restarts the stretch from zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        reset_b_d = reset_b_q;
        if (w_req) begin
            state_d   = ASSERT;
            cnt_d     = '0;
            idx_d     = '0;
            reset_b_d = '0;
        end else begin
            case (state_q)
                ASSERT: begin
                    reset_b_d = '0;
                    if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                        cnt_d        = '0;
                        idx_d        = '0;
                        reset_b_d[0] = 1'b1;
                        state_d      = (NUM_DOMAINS == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            if (IDX_W'(k) == idx_d) begin
                                reset_b_d[k] = 1'b1;
                            end
                        end
                        if (idx_d == IDX_W'(NUM_DOMAINS - 1)) begin
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cnt_d     = '0;
                    reset_b_d = '1;
                end
                default: begin
                    state_d   = ASSERT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    reset_b_d = '0;
                end
            endcase
        end
        busy_d = ~&reset_b_d;
    end

    // Sticky cause: a source accepted this cycle overrides a same-cycle clear
    always_comb begin
        cause_d = cause_clr ? '0 : cause_q;
        if (w_ext_low) begin
            cause_d = cause_d | cause_bit(CAUSE_EXT);
        end
        if (sw_reset_req) begin
            cause_d = cause_d | cause_bit(CAUSE_SW);
        end
        if (w_wdt_fire) begin
            cause_d = cause_d | cause_bit(CAUSE_WDT);
        end
    end

    // Sequencer, output and cause registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            reset_b_q <= '0;
            busy_q    <= 1'b1;
            cause_q   <= cause_bit(CAUSE_POR);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            reset_b_q <= reset_b_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
        end
    end

    assign reset_b_out = reset_b_q;
    assign seq_busy    = busy_q;
    assign reset_cause = cause_q;

endmodule : m6809_reset_seq
`default_nettype wire

// File: tb/tb_m6809_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_m6809_reset_seq
// Description : Self-checking bench for m6809_reset_seq. Directed vector table
//               for power-on, software, re-trigger, cause and button cases,
//               watchdog sequences, then random stimulus against a reference
//               model built from release deadlines and sample windows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m6809_reset_seq;
    localparam int ND     = 3;
    localparam int ST     = 16;
    localparam int SG     = 4;
    localparam int DB     = 8;
    localparam int WDT    = 32;
    localparam int RUN_AT = ST + (ND - 1) * SG;

    logic          clk;
    logic          reset;
    logic          ext_reset_b;
    logic          sw_reset_req;
    logic          wdt_enable;
    logic          wdt_kick;
    logic          cause_clr;
    logic [ND-1:0] reset_b_out;
    logic          seq_busy;
    logic [3:0]    reset_cause;

    int total = 0;
    int bad   = 0;

    m6809_reset_seq #(
        .NUM_DOMAINS     (ND),
        .STRETCH_CYCLES  (ST),
        .STAGGER_CYCLES  (SG),
        .DEBOUNCE_CYCLES (DB),
        .WDT_CYCLES      (WDT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_reset_b  (ext_reset_b),
        .sw_reset_req (sw_reset_req),
        .wdt_enable   (wdt_enable),
        .wdt_kick     (wdt_kick),
        .cause_clr    (cause_clr),
        .reset_b_out  (reset_b_out),
        .seq_busy     (seq_busy),
        .reset_cause  (reset_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: absolute edge count, edge of the last request, raw
    // button samples since reset, accepted button level, watchdog run count
    int         n_edge   = 0;
    int         last_req = 0;
    int         wcnt     = 0;
    bit         lvl      = 1'b1;
    bit         raw[$];
    logic [3:0] mc       = 4'b0001;

    function automatic bit raw_at(input int i);
        if (i < 0) return 1'b1;
        return raw[i];
    endfunction

    task automatic model_edge(input bit rst, input bit sw, input bit clr,
                              input bit ext, input bit en, input bit kick);
        bit run_before, ext_low, fire, req, flip;
        int r;
        n_edge++;
        if (rst) begin
            last_req = n_edge;
            mc       = 4'b0001;
            lvl      = 1'b1;
            wcnt     = 0;
            raw.delete();
            return;
        end
        run_before = ((n_edge - 1 - last_req) >= RUN_AT);
        ext_low    = !lvl;
        fire       = 1'b0;
`ifdef M6809_WDT_EN
        if (run_before && en && !kick) begin
            if (wcnt == WDT - 1) begin
                fire = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else if (!run_before || kick) begin
            wcnt = 0;
        end
`else
        if (en && kick) wcnt = 0;
`endif
        req = ext_low | sw | fire;
        mc  = (clr ? 4'b0000 : mc) | {fire, sw, ext_low, 1'b0};
        r   = raw.size();
        raw.push_back(ext);
        flip = 1'b1;
        for (int j = 2; j < 2 + DB; j++) begin
            if (raw_at(r - j) == lvl) flip = 1'b0;
        end
        if (flip) lvl = !lvl;
        if (req) last_req = n_edge;
    endtask

    function automatic logic [7:0] m_exp();
        logic [ND-1:0] o;
        for (int k = 0; k < ND; k++) begin
            o[k] = ((n_edge - last_req) >= ST + k * SG);
        end
        return {o, ~&o, mc};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n_edge);
        end
    endtask

    task automatic step(input bit rst, input bit sw, input bit clr,
                        input bit ext, input bit en, input bit kick);
        reset        = rst;
        sw_reset_req = sw;
        cause_clr    = clr;
        ext_reset_b  = ext;
        wdt_enable   = en;
        wdt_kick     = kick;
        @(posedge clk);
        model_edge(rst, sw, clr, ext, en, kick);
        #1;
        check("model", {24'd0, reset_b_out, seq_busy, reset_cause}, {24'd0, m_exp()});
    endtask

    typedef struct {
        int         ncyc;
        bit         sw;
        bit         clr;
        bit         ext;
        logic [2:0] out;
        bit         busy;
        logic [3:0] cause;
    } vec_t;

    function automatic vec_t mk(input int n, input bit sw, input bit clr, input bit ext,
                                input logic [2:0] out, input bit busy, input logic [3:0] cause);
        vec_t v;
        v.ncyc  = n;
        v.sw    = sw;
        v.clr   = clr;
        v.ext   = ext;
        v.out   = out;
        v.busy  = busy;
        v.cause = cause;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int  cnt;
        bit  fired;
        int  runleft;
        bit  e_r, en_r;

        // Power-on, software reset, mid-release re-trigger, cause clear
        tbl.push_back(mk(15, 0, 0, 1, 3'b000, 1, 4'b0001));
        tbl.push_back(mk( 1, 0, 0, 1, 3'b001, 1, 4'b0001));
        tbl.push_back(mk( 3, 0, 0, 1, 3'b001, 1, 4'b0001));
        tbl.push_back(mk( 1, 0, 0, 1, 3'b011, 1, 4'b0001));
        tbl.push_back(mk( 4, 0, 0, 1, 3'b111, 0, 4'b0001));
        tbl.push_back(mk( 1, 1, 0, 1, 3'b000, 1, 4'b0101));
        tbl.push_back(mk(15, 0, 0, 1, 3'b000, 1, 4'b0101));
        tbl.push_back(mk( 1, 0, 0, 1, 3'b001, 1, 4'b0101));
        tbl.push_back(mk( 1, 1, 1, 1, 3'b000, 1, 4'b0100));
        tbl.push_back(mk( 1, 0, 1, 1, 3'b000, 1, 4'b0000));
        tbl.push_back(mk(22, 0, 0, 1, 3'b011, 1, 4'b0000));
        tbl.push_back(mk( 1, 0, 0, 1, 3'b111, 0, 4'b0000));
        // Button: short glitch ignored, then a 20-cycle press
        tbl.push_back(mk( 3, 0, 0, 0, 3'b111, 0, 4'b0000));
        tbl.push_back(mk(20, 0, 0, 1, 3'b111, 0, 4'b0000));
        tbl.push_back(mk( 9, 0, 0, 0, 3'b111, 0, 4'b0000));
        tbl.push_back(mk( 1, 0, 0, 0, 3'b111, 0, 4'b0000));
        tbl.push_back(mk( 1, 0, 0, 0, 3'b000, 1, 4'b0010));
        tbl.push_back(mk( 9, 0, 0, 0, 3'b000, 1, 4'b0010));
        tbl.push_back(mk(25, 0, 0, 1, 3'b000, 1, 4'b0010));
        tbl.push_back(mk( 1, 0, 0, 1, 3'b001, 1, 4'b0010));
        tbl.push_back(mk( 8, 0, 0, 1, 3'b111, 0, 4'b0010));

        reset        = 1'b1;
        ext_reset_b  = 1'b1;
        sw_reset_req = 1'b0;
        cause_clr    = 1'b0;
        wdt_enable   = 1'b0;
        wdt_kick     = 1'b0;

        repeat (5) step(1, 0, 0, 1, 0, 0);
        check("por_hold", {24'd0, reset_b_out, seq_busy, reset_cause}, {24'd0, 3'b000, 1'b1, 4'b0001});

        for (int i = 0; i < tbl.size(); i++) begin
            repeat (tbl[i].ncyc) step(0, tbl[i].sw, tbl[i].clr, tbl[i].ext, 0, 0);
            check($sformatf("vec%0d", i), {24'd0, reset_b_out, seq_busy, reset_cause},
                  {24'd0, tbl[i].out, tbl[i].busy, tbl[i].cause});
        end

        // Watchdog enabled and never kicked
        step(0, 0, 1, 1, 0, 0);
`ifdef M6809_WDT_EN
        cnt   = 0;
        fired = 1'b0;
        while (!fired && cnt < 40) begin
            step(0, 0, 0, 1, 1, 0);
            cnt++;
            if (reset_b_out == 3'b000) fired = 1'b1;
        end
        check("wdt_fire_edges", cnt, 32);
        check("wdt_cause", {28'd0, reset_cause}, {28'd0, 4'b1000});
`else
        repeat (80) step(0, 0, 0, 1, 1, 0);
        check("wdt_off_out", {29'd0, reset_b_out}, {29'd0, 3'b111});
        check("wdt_off_cause", {28'd0, reset_cause}, 32'd0);
`endif
        repeat (30) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);

        // Watchdog kicked every 20 cycles must never fire
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 0, 1, 1, (i % 20) == 19);
        end
        check("kick_out", {29'd0, reset_b_out}, {29'd0, 3'b111});
        check("kick_cause", {28'd0, reset_cause}, 32'd0);

        // Random traffic against the reference model
        runleft = 0;
        e_r     = 1'b1;
        en_r    = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (runleft == 0) begin
                e_r     = ($urandom_range(0, 2) != 0);
                runleft = e_r ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 14));
            end
            runleft--;
            if ($urandom_range(0, 49) == 0) en_r = !en_r;
            step(0, ($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0), e_r, en_r,
                 ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_m6809_reset_seq
`default_nettype wire
